// File: rtl/nfive_rf_gen.sv
// Multi-ported register file: two combinational read ports, one write port, and a
// bulk clear that sweeps one register per cycle. Optional write-to-read bypass: RF_BYPASS_EN.
module nfive_rf_gen #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            WR,
  input  logic [AW-1:0]   RW,
  input  logic [XLEN-1:0] DW,
  input  logic [AW-1:0]   RA,
  input  logic [AW-1:0]   RB,
  output logic [XLEN-1:0] DA,
  output logic [XLEN-1:0] DB,
  input  logic            CLR,
  output logic            BUSY
);

  localparam int unsigned DEPTH = 1 << AW;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  logic            r_state;
  logic [AW-1:0]   r_cnt;
  logic [XLEN-1:0] r_mem [DEPTH];

  logic            w_busy;
  logic            w_wr_en;
  logic [XLEN-1:0] w_da;
  logic [XLEN-1:0] w_db;

  assign w_busy  = (r_state == ST_CLEAR);
  // Register 0 is never written when it is hardwired to zero.
  assign w_wr_en = WR && !w_busy && !((ZERO_REG != 0) && (RW == '0));

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_en) begin
            r_mem[RW] <= DW;
          end
          if (CLR) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_mem[r_cnt] <= '0;
          r_cnt        <= r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_da = r_mem[RA];
    w_db = r_mem[RB];
`ifdef RF_BYPASS_EN
    if (w_wr_en && (RW == RA)) w_da = DW;
    if (w_wr_en && (RW == RB)) w_db = DW;
`endif
    if ((ZERO_REG != 0) && (RA == '0)) w_da = '0;
    if ((ZERO_REG != 0) && (RB == '0)) w_db = '0;
  end

  assign DA   = w_da;
  assign DB   = w_db;
  assign BUSY = w_busy;

endmodule

// File: tb/tb_nfive_rf_gen.sv
// Scoreboard bench for nfive_rf_gen: three instances (32x32 zero-reg, 32x32 plain, 64x8)
// share control stimulus; a queue-based monitor compares against a behavioural model.
module tb_nfive_rf_gen;

  logic        clk = 1'b0;
  logic        rst_n, wr, clr;
  logic [4:0]  rw, ra, rb;
  logic [31:0] dw, dwh;

  logic [31:0] a_da, a_db, z_da, z_db;
  logic [63:0] w_da, w_db;
  logic        a_busy, z_busy, w_busy;

  always #5 clk = ~clk;

  nfive_rf_gen #(.XLEN(32), .AW(5), .ZERO_REG(1)) u_a (
    .HCLK(clk), .HRESETn(rst_n), .WR(wr), .RW(rw), .DW(dw), .RA(ra), .RB(rb),
    .DA(a_da), .DB(a_db), .CLR(clr), .BUSY(a_busy)
  );

  nfive_rf_gen #(.XLEN(32), .AW(5), .ZERO_REG(0)) u_z (
    .HCLK(clk), .HRESETn(rst_n), .WR(wr), .RW(rw), .DW(dw), .RA(ra), .RB(rb),
    .DA(z_da), .DB(z_db), .CLR(clr), .BUSY(z_busy)
  );

  nfive_rf_gen #(.XLEN(64), .AW(3), .ZERO_REG(1)) u_w (
    .HCLK(clk), .HRESETn(rst_n), .WR(wr), .RW(rw[2:0]), .DW({dwh, dw}), .RA(ra[2:0]),
    .RB(rb[2:0]), .DA(w_da), .DB(w_db), .CLR(clr), .BUSY(w_busy)
  );

  // Reference state: register arrays plus the index being swept (-1 when idle).
  logic [31:0] m_a [32];
  logic [31:0] m_z [32];
  logic [63:0] m_w [8];
  int          pos_a = -1;
  int          pos_w = -1;
  bit          model_ok = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] a_da, a_db, z_da, z_db;
    logic [63:0] w_da, w_db;
    logic        busy_a, busy_w;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] ref_rd32(input bit zr, input logic [4:0] addr);
    logic [31:0] v;
    if (zr && addr == 5'd0) return '0;
    v = zr ? m_a[addr] : m_z[addr];
`ifdef RF_BYPASS_EN
    if (wr && pos_a < 0 && rw == addr) v = dw;
`endif
    return v;
  endfunction

  function automatic logic [63:0] ref_rd64(input logic [2:0] addr);
    logic [63:0] v;
    if (addr == 3'd0) return '0;
    v = m_w[addr];
`ifdef RF_BYPASS_EN
    if (wr && pos_w < 0 && rw[2:0] == addr) v = {dwh, dw};
`endif
    return v;
  endfunction

  // Drive one cycle of stimulus, queue the expected outputs, then advance the model.
  task automatic step(input bit r, input bit w, input bit c, input logic [4:0] a_rw,
                      input logic [4:0] a_ra, input logic [4:0] a_rb, input logic [31:0] d,
                      input logic [31:0] dh, input string tag);
    exp_t e;
    rst_n = r; wr = w; clr = c; rw = a_rw; ra = a_ra; rb = a_rb; dw = d; dwh = dh;
    if (model_ok) begin
      e.tag    = tag;
      e.a_da   = ref_rd32(1'b1, ra);
      e.a_db   = ref_rd32(1'b1, rb);
      e.z_da   = ref_rd32(1'b0, ra);
      e.z_db   = ref_rd32(1'b0, rb);
      e.w_da   = ref_rd64(ra[2:0]);
      e.w_db   = ref_rd64(rb[2:0]);
      e.busy_a = (pos_a >= 0);
      e.busy_w = (pos_w >= 0);
      q.push_back(e);
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) begin
        m_a[i] = '0;
        m_z[i] = '0;
      end
      for (int i = 0; i < 8; i++) m_w[i] = '0;
      pos_a    = -1;
      pos_w    = -1;
      model_ok = 1'b1;
    end else begin
      if (pos_a >= 0) begin
        m_a[pos_a] = '0;
        m_z[pos_a] = '0;
        pos_a++;
        if (pos_a == 32) pos_a = -1;
      end else begin
        if (w) begin
          if (a_rw != 5'd0) m_a[a_rw] = d;
          m_z[a_rw] = d;
        end
        if (c) pos_a = 0;
      end
      if (pos_w >= 0) begin
        m_w[pos_w] = '0;
        pos_w++;
        if (pos_w == 8) pos_w = -1;
      end else begin
        if (w && a_rw[2:0] != 3'd0) m_w[a_rw[2:0]] = {dh, d};
        if (c) pos_w = 0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.tag, ".a_da"}, 64'(a_da), 64'(e.a_da));
      cmp({e.tag, ".a_db"}, 64'(a_db), 64'(e.a_db));
      cmp({e.tag, ".z_da"}, 64'(z_da), 64'(e.z_da));
      cmp({e.tag, ".z_db"}, 64'(z_db), 64'(e.z_db));
      cmp({e.tag, ".w_da"}, w_da, e.w_da);
      cmp({e.tag, ".w_db"}, w_db, e.w_db);
      cmp({e.tag, ".a_busy"}, 64'(a_busy), 64'(e.busy_a));
      cmp({e.tag, ".z_busy"}, 64'(z_busy), 64'(e.busy_a));
      cmp({e.tag, ".w_busy"}, 64'(w_busy), 64'(e.busy_w));
    end
  end

  initial begin
    int ba, bw;
    rst_n = 1'b0; wr = 1'b0; clr = 1'b0; rw = '0; ra = '0; rb = '0; dw = '0; dwh = '0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, "rst");
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd9, 32'd0, 32'd0, "reset_state");

    step(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd100, 32'd0, "wr_r5");
    step(1'b1, 1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 32'd200, 32'd0, "wr_r10");
    step(1'b1, 1'b1, 1'b0, 5'd20, 5'd0, 5'd0, 32'd999, 32'd0, "wr_r20");
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd10, 32'd0, 32'd0, "rd_5_10");
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd20, 5'd20, 32'd0, 32'd0, "rd_20");

    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, "wr_r0");
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, "rd_r0");

    step(1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 32'h55, 32'd0, "byp_r7");
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd7, 32'd0, 32'd0, "rd_r7");
    step(1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, "wr_ones_r7");
    step(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd15, 32'd0, 32'd0, "rd_ones_r7");

    for (int i = 1; i < 32; i++)
      step(1'b1, 1'b1, 1'b0, 5'(i), 5'(i), 5'(i - 1), $urandom | 32'd1, $urandom | 32'd1, "fill");
    ba = 0;
    bw = 0;
    step(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, "clr");
    if (a_busy) ba++;
    if (w_busy) bw++;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, pos_a >= 0, 1'b0, 5'd3, 5'(i), 5'd3, 32'h1234, 32'h5678, "busy_wr");
      if (a_busy) ba++;
      if (w_busy) bw++;
    end
    cmp("busy_cycles_a", 64'(ba), 64'd32);
    cmp("busy_cycles_w", 64'(bw), 64'd8);
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'(i), 5'(31 - i), 32'd0, 32'd0, "rd_after_clr");

    for (int i = 1; i < 32; i++)
      step(1'b1, 1'b1, 1'b0, 5'(i), 5'(i), 5'd0, $urandom | 32'd1, $urandom, "refill");
    step(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, "clr2");
    for (int i = 0; i < 9; i++)
      step(1'b1, 1'b0, 1'b1, 5'd0, 5'(i + 20), 5'(i), 32'd0, 32'd0, "clr2_run");
    step(1'b0, 1'b1, 1'b1, 5'd4, 5'd25, 5'd4, 32'hAA, 32'd0, "rst_mid_clr");
    cmp("abort_busy", 64'(a_busy), 64'd0);
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b0, 1'b0, 5'd0, 5'(i), 5'(i ^ 5'h1F), 32'd0, 32'd0, "rd_after_abort");
    step(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, "clr_after_rst");
    cmp("clr_accepted", 64'(a_busy), 64'd1);

    for (int i = 0; i < 600; i++)
      step($urandom_range(99) != 0, $urandom_range(1), $urandom_range(39) == 0,
           5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, "rand");

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
